// File: rtl/mux_scan_seq.sv
// Select sequencer for a 4:1 bit mux: scans enabled channels, captures a frame.
// Optional frame parity output enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_seq #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] ch_mask,
  output logic [1:0] s,
  input  logic       mux_out,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       start_drop
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       frame_par
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_t        state, state_d;
  logic [1:0]    s_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    frame_d;
  logic          valid_d;
  logic          drop_d;
  logic [2:0]    nx;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] l;
    l = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) l = 2'(i);
    return l;
  endfunction

  // {found, index} of the lowest enabled channel above cur
  function automatic logic [2:0] next_ch(input logic [3:0] m,
                                         input logic [1:0] cur);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i] && i > int'(cur)) r = {1'b1, 2'(i)};
    return r;
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    state_d = state;
    s_d     = s;
    cnt_d   = cnt;
    mask_d  = mask_q;
    frame_d = frame;
    valid_d = frame_valid;
    drop_d  = start && (state != IDLE);
    nx      = next_ch(mask_q, s);
    unique case (state)
      IDLE: begin
        if (start && ch_mask != 4'd0) begin
          mask_d  = ch_mask;
          frame_d = 4'd0;
          cnt_d   = '0;
          s_d     = lowest(ch_mask);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt != LAST) begin
          cnt_d = cnt + 1'b1;
        end else begin
          frame_d[s] = mux_out;
          cnt_d      = '0;
          if (nx[2]) begin
            s_d = nx[1:0];
          end else begin
            valid_d = 1'b1;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (frame_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s           <= 2'd0;
      cnt         <= '0;
      mask_q      <= 4'd0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
      start_drop  <= 1'b0;
    end else begin
      state       <= state_d;
      s           <= s_d;
      cnt         <= cnt_d;
      mask_q      <= mask_d;
      frame       <= frame_d;
      frame_valid <= valid_d;
      start_drop  <= drop_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_par <= 1'b0;
    else        frame_par <= ^frame_d;
  end
`endif

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: vector table of scans plus
// handshake, start_drop, empty-mask and async-reset sequences.
module tb_mux_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] ch_mask;
  logic [1:0] s;
  logic       mux_out;
  logic       busy;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       start_drop;
  logic [3:0] in_val;
`ifdef MUX_SCAN_PARITY_EN
  logic       frame_par;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mux_out = in_val[s];

  mux_scan_seq #(.DWELL(4), .CW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ch_mask     (ch_mask),
    .s           (s),
    .mux_out     (mux_out),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .start_drop  (start_drop)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .frame_par   (frame_par)
`endif
  );

  typedef struct {
    logic [3:0] mask;
    logic [3:0] inv;
    logic [3:0] exp_frame;
    int         exp_lat;
    logic       exp_par;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a scan at the current negedge; returns at the negedge after valid
  task automatic do_scan(input logic [3:0] m, input logic [3:0] iv,
                         output logic [3:0] fr, output int lat,
                         output logic [3:0] vis);
    start   = 1'b1;
    ch_mask = m;
    in_val  = iv;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    ch_mask = ~m;
    lat = 0;
    vis = 4'd0;
    while (!frame_valid && lat < 200) begin
      vis[s] = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    fr = frame;
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_ready = 1'b0;
    chk("accept_valid", int'(frame_valid), 0);
    chk("accept_busy", int'(busy), 0);
  endtask

  initial begin
    logic [3:0] fr, vis;
    int lat;
    logic acc;

    vt[0] = '{4'b1111, 4'b1010, 4'b1010, 16, 1'b0};
    vt[1] = '{4'b0101, 4'b1111, 4'b0101,  8, 1'b0};
    vt[2] = '{4'b1000, 4'b1000, 4'b1000,  4, 1'b1};
    vt[3] = '{4'b0110, 4'b1001, 4'b0000,  8, 1'b0};
    vt[4] = '{4'b1011, 4'b0111, 4'b0011, 12, 1'b0};
    vt[5] = '{4'b0001, 4'b0000, 4'b0000,  4, 1'b0};
    vt[6] = '{4'b1111, 4'b0111, 4'b0111, 16, 1'b1};
    vt[7] = '{4'b1111, 4'b0011, 4'b0011, 16, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    ch_mask = 4'd0;
    frame_ready = 1'b0;
    in_val = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s", int'(s), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame", int'(frame), 0);
    chk("rst_valid", int'(frame_valid), 0);
    chk("rst_drop", int'(start_drop), 0);

    for (int i = 0; i < 8; i++) begin
      do_scan(vt[i].mask, vt[i].inv, fr, lat, vis);
      chk($sformatf("v%0d_frame", i), int'(fr), int'(vt[i].exp_frame));
      chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_visit", i), int'(vis), int'(vt[i].mask));
`ifdef MUX_SCAN_PARITY_EN
      chk($sformatf("v%0d_par", i), int'(frame_par), int'(vt[i].exp_par));
`endif
      accept();
    end

    // backpressure: frame and valid hold while ready is low
    do_scan(4'b1111, 4'b1010, fr, lat, vis);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", int'(frame_valid), 1);
      chk("hold_frame", int'(frame), 4'b1010);
      chk("hold_busy", int'(busy), 1);
    end
    accept();
    chk("post_accept_frame", int'(frame), 4'b1010);

    // start while busy is dropped with a one-cycle pulse
    start = 1'b1;
    ch_mask = 4'b1111;
    in_val = 4'b1010;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b1;
    ch_mask = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("drop_pulse", int'(start_drop), 1);
    @(posedge clk);
    @(negedge clk);
    chk("drop_clear", int'(start_drop), 0);
    lat = 6;
    while (!frame_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("drop_lat", lat, 16);
    chk("drop_frame", int'(frame), 4'b1010);
    accept();
    acc = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      acc = acc | busy | frame_valid;
    end
    chk("no_second_scan", int'(acc), 0);

    // empty mask is ignored
    start = 1'b1;
    ch_mask = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    acc = 1'b0;
    repeat (10) begin
      acc = acc | busy | frame_valid | start_drop;
      @(posedge clk);
      @(negedge clk);
    end
    chk("empty_mask", int'(acc), 0);

    // async reset mid-scan, then restart
    start = 1'b1;
    ch_mask = 4'b1111;
    in_val = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    chk("pre_rst_s", int'(s), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s", int'(s), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(frame_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_valid", int'(frame_valid), 0);
    do_scan(4'b1111, 4'b0110, fr, lat, vis);
    chk("restart_frame", int'(fr), 4'b0110);
    chk("restart_lat", lat, 16);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
